perm_gen_pipe: RTL and testbench
================================

# perm_gen_pipe

Pipelined, parametrised pseudo-random permutation generator. Emits one permutation of {0..N-1} (N = 2^LOG2N, packed LOG2N bits per element) per accepted request. Each of STAGES stages applies a keyed rotate-and-stride shuffle driven by a seedable counter. A valid/ready output handshake with full-pipeline stall lets it feed shuffle and test-sequence consumers directly.

## Interface
- LOG2N, default 4: element width; N = 2^LOG2N elements (legal 1..6)
- STAGES, default 8: shuffle stages = pipeline depth (legal 1..16)
- Derived: PW = N*LOG2N (permutation bus width); CW = STAGES*LOG2N (counter width)
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- gen_en  in  1  request one permutation this cycle
- gen_ready  out  1  request accepted when gen_en && gen_ready
- seed_load  in  1  load counter from seed_in
- seed_in  in  CW  counter load value
- out_valid  out  1  out_perm/out_ctr valid
- out_ready  in  1  consumer accepts output
- out_perm  out  PW  permutation; element i at bits [i*LOG2N +: LOG2N]
- out_ctr  out  CW  counter value that produced out_perm

## Operation
- Counter ctr (CW bits, reset 0). On acceptance, the current ctr enters stage 0 and ctr <= ctr+1, wrapping mod 2^CW.
- seed_load: ctr <= seed_in on that edge regardless of stall; it overrides the increment. An acceptance in the same cycle uses the old ctr. In-flight entries are unaffected.
- Stage k (0..STAGES-1), input vector A, output B:
  - shift s_k = ctr[k*LOG2N +: LOG2N], taken from the tag carried with the entry.
  - multiplier m_k = (2k+3) mod N. Always odd, so each stage is a bijection.
  - B[i] = A[(m_k*i + s_k) mod N]; all arithmetic is LOG2N-bit and wraps.
- Stage 0 input is identity: A[i] = i.
- Each stage is registered. Per-stage valid bit plus data and carried ctr tag. The last stage register drives out_perm, out_ctr and out_valid.
- Stall: stall = out_valid && !out_ready; gen_ready = !stall.
  - While stalled, every stage register holds, including bubbles.
  - Otherwise all stages advance; stage 0 valid <= (gen_en && gen_ready).
- gen_en while stalled is ignored and ctr does not increment.
- Bubbles are not compressed; behaviour is a global-enable shift pipeline.
- Output contract: out_perm holds each value 0..N-1 exactly once whenever out_valid = 1.

## Timing
- Reset: ctr = 0; all valid bits 0; all data and tag registers 0. Therefore out_valid = 0, out_perm = 0, out_ctr = 0, gen_ready = 1.
- rst mid-operation discards all in-flight entries immediately (asynchronous). First acceptance after rst deassert uses ctr = 0.
- Latency: request accepted on edge E → out_valid = 1 after edge E+STAGES-1, i.e. STAGES cycles.
- Throughput: one permutation per cycle when out_ready = 1.
- Output transfer: occurs on an edge with out_valid && out_ready. out_perm/out_ctr stay stable while out_valid && !out_ready.
- gen_ready is combinational from out_valid (registered) and out_ready. There is no path from gen_en.
- ctr wrap: all-ones + 1 → 0 with no flag.

## Test plan
- Identity, defaults. Reset, then gen_en = 1 for one cycle, out_ready = 1 → after 8 cycles out_valid = 1 for exactly one cycle, out_ctr = 0, out_perm = 0xFEDCBA9876543210.
  - Why: all shifts are 0, and the product of the multipliers 3·5·7·9·11·13·15·1 ≡ 1 mod 16.
- Shift propagation.
  - ctr = 1 → out_perm = 0x0FEDCBA987654321 (element i = (i+1) mod 16).
  - seed_load with seed_in = 0x10, then request → out_ctr = 0x10, out_perm = 0x210FEDCBA9876543 (element i = (i+3) mod 16).
- Streaming. gen_en = 1 for 20 cycles, out_ready = 1 → 20 consecutive valids with out_ctr 0..19. Every out_perm is a bijection (scoreboard against a reference model).
- Backpressure.
  - Stream with out_ready = 0 for 5 cycles after first valid → gen_ready = 0, ctr frozen, outputs stable.
  - Resume → no loss or duplication of out_ctr values.
- Seed/wrap.
  - seed_load with seed_in = 0xFFFFFFFF and gen_en in the same cycle → that entry carries the old ctr.
  - Next two entries carry 0xFFFFFFFF, then 0x00000000.
- Reset mid-stream. Assert rst with 4 entries in flight → out_valid = 0 at once, no stale outputs after release. First new out_ctr = 0.

Source files
------------

// File: rtl/perm_gen_pipe.sv
// rtl/perm_gen_pipe.sv - pipelined keyed rotate-and-stride permutation generator
module perm_gen_pipe #(
   parameter int LOG2N  = 4,
   parameter int STAGES = 8,
   localparam int N     = 1 << LOG2N,
   localparam int PW    = N * LOG2N,
   localparam int CW    = STAGES * LOG2N
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          gen_en,
   output logic          gen_ready,
   input  logic          seed_load,
   input  logic [CW-1:0] seed_in,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [PW-1:0] out_perm,
   output logic [CW-1:0] out_ctr
);

   logic [CW-1:0]     ctr;
   logic              stall;
   logic              accept;
   logic [PW-1:0]     ident;

   logic [PW-1:0]     data_q [STAGES];
   logic [CW-1:0]     tag_q  [STAGES];
   logic [STAGES-1:0] vld_q;
   logic [PW-1:0]     data_d [STAGES];
   logic [CW-1:0]     tag_d  [STAGES];
   logic [STAGES-1:0] vld_d;

   // B[i] = A[(m*i + s) mod N]; m is odd so the mapping is a bijection
   function automatic logic [PW-1:0] shuffle(input logic [PW-1:0]    a,
                                             input logic [LOG2N-1:0] m,
                                             input logic [LOG2N-1:0] s);
      logic [PW-1:0]    b;
      logic [LOG2N-1:0] idx;
      b = '0;
      for (int i = 0; i < N; i++) begin
         idx = m * LOG2N'(i) + s;
         b[i*LOG2N +: LOG2N] = a[int'(idx)*LOG2N +: LOG2N];
      end
      return b;
   endfunction

   assign stall     = out_valid && !out_ready;
   assign gen_ready = !stall;
   assign accept    = gen_en && gen_ready;

   assign out_valid = vld_q[STAGES-1];
   assign out_perm  = data_q[STAGES-1];
   assign out_ctr   = tag_q[STAGES-1];

   always_comb begin
      ident = '0;
      for (int i = 0; i < N; i++)
         ident[i*LOG2N +: LOG2N] = LOG2N'(i);

      vld_d     = '0;
      vld_d[0]  = accept;
      tag_d[0]  = ctr;
      data_d[0] = shuffle(ident, LOG2N'(3 % N), ctr[LOG2N-1:0]);
      for (int k = 1; k < STAGES; k++) begin
         vld_d[k]  = vld_q[k-1];
         tag_d[k]  = tag_q[k-1];
         data_d[k] = shuffle(data_q[k-1], LOG2N'((2*k + 3) % N),
                             tag_q[k-1][k*LOG2N +: LOG2N]);
      end
   end

   // Seed load overrides the increment; an acceptance in the same cycle still used the old ctr
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctr   <= '0;
         vld_q <= '0;
         for (int k = 0; k < STAGES; k++) begin
            data_q[k] <= '0;
            tag_q[k]  <= '0;
         end
      end else begin
         if (seed_load)
            ctr <= seed_in;
         else if (accept)
            ctr <= ctr + CW'(1);
         if (!stall) begin
            vld_q <= vld_d;
            for (int k = 0; k < STAGES; k++) begin
               data_q[k] <= data_d[k];
               tag_q[k]  <= tag_d[k];
            end
         end
      end
   end

endmodule

// File: tb/tb_perm_gen_pipe.sv
// tb/tb_perm_gen_pipe.sv - scoreboard bench for perm_gen_pipe with a reference permutation model
module tb_perm_gen_pipe;

   localparam int LOG2N  = 4;
   localparam int STAGES = 8;
   localparam int N      = 1 << LOG2N;
   localparam int PW     = N * LOG2N;
   localparam int CW     = STAGES * LOG2N;

   typedef struct {
      logic [CW-1:0] ctr;
      logic [PW-1:0] perm;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          gen_en;
   logic          gen_ready;
   logic          seed_load;
   logic [CW-1:0] seed_in;
   logic          out_valid;
   logic          out_ready;
   logic [PW-1:0] out_perm;
   logic [CW-1:0] out_ctr;

   int            total = 0;
   int            bad   = 0;
   int            n_out = 0;
   exp_t          exp_q[$];
   logic [CW-1:0] tb_ctr;
   logic          prev_hold;
   logic [PW-1:0] hold_perm;
   logic [CW-1:0] hold_ctr;

   perm_gen_pipe #(.LOG2N(LOG2N), .STAGES(STAGES)) dut (
      .clk(clk), .rst(rst), .gen_en(gen_en), .gen_ready(gen_ready),
      .seed_load(seed_load), .seed_in(seed_in), .out_valid(out_valid),
      .out_ready(out_ready), .out_perm(out_perm), .out_ctr(out_ctr)
   );

   always #5 clk = ~clk;

   // Element i after all stages, computed stage by stage on plain integer arrays
   function automatic logic [PW-1:0] model_perm(input logic [CW-1:0] c);
      int a[N];
      int b[N];
      int s;
      int m;
      logic [PW-1:0] r;
      for (int i = 0; i < N; i++) a[i] = i;
      for (int k = 0; k < STAGES; k++) begin
         s = int'((c >> (k*LOG2N)) & CW'(N-1));
         m = (2*k + 3) % N;
         for (int i = 0; i < N; i++) b[i] = a[(m*i + s) % N];
         a = b;
      end
      r = '0;
      for (int i = 0; i < N; i++) r[i*LOG2N +: LOG2N] = LOG2N'(a[i]);
      return r;
   endfunction

   function automatic bit is_bijection(input logic [PW-1:0] p);
      logic [N-1:0] seen;
      seen = '0;
      for (int i = 0; i < N; i++) seen[p[i*LOG2N +: LOG2N]] = 1'b1;
      return &seen;
   endfunction

   // Scoreboard: pop/compare outputs first, then record the request accepted this cycle
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) begin
            total++;
            if (!out_valid || out_perm !== hold_perm || out_ctr !== hold_ctr) begin
               bad++;
               $display("FAIL hold_stable: got v=%0b ctr=%h perm=%h want v=1 ctr=%h perm=%h",
                        out_valid, out_ctr, out_perm, hold_ctr, hold_perm);
            end
         end
         total++;
         if (gen_ready !== !(out_valid && !out_ready)) begin
            bad++;
            $display("FAIL gen_ready: got %0b want %0b", gen_ready, !(out_valid && !out_ready));
         end
         if (out_valid && out_ready) begin
            n_out++;
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_output: got ctr=%h perm=%h want no output", out_ctr, out_perm);
            end else begin
               e = exp_q.pop_front();
               if (out_ctr !== e.ctr || out_perm !== e.perm) begin
                  bad++;
                  $display("FAIL sb_compare: got ctr=%h perm=%h want ctr=%h perm=%h",
                           out_ctr, out_perm, e.ctr, e.perm);
               end
            end
            total++;
            if (!is_bijection(out_perm)) begin
               bad++;
               $display("FAIL bijection: got perm=%h want each element once", out_perm);
            end
         end
         prev_hold = out_valid && !out_ready;
         hold_perm = out_perm;
         hold_ctr  = out_ctr;
         if (gen_en && gen_ready) begin
            e.ctr  = tb_ctr;
            e.perm = model_perm(tb_ctr);
            exp_q.push_back(e);
         end
         if (seed_load)
            tb_ctr = seed_in;
         else if (gen_en && gen_ready)
            tb_ctr = tb_ctr + CW'(1);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [PW-1:0] got, input logic [PW-1:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic do_reset();
      #3;
      rst = 1'b1;
      exp_q.delete();
      tb_ctr = '0;
      #1;
      check("rst_out_valid", PW'(out_valid), PW'(0));
      step();
      step();
      #2;
      rst = 1'b0;
      step();
   endtask

   task automatic req_check(input string name, input logic [PW-1:0] want_perm,
                            input logic [CW-1:0] want_ctr);
      int n;
      gen_en = 1'b1;
      step();
      gen_en = 1'b0;
      n = 1;
      while (!out_valid && n < 40) begin
         step();
         n++;
      end
      check({name, "_latency"}, PW'(n), PW'(STAGES));
      check({name, "_perm"}, out_perm, want_perm);
      check({name, "_ctr"}, PW'(out_ctr), PW'(want_ctr));
      step();
      check({name, "_one_cycle"}, PW'(out_valid), PW'(0));
   endtask

   task automatic drain();
      int n;
      gen_en    = 1'b0;
      seed_load = 1'b0;
      out_ready = 1'b1;
      n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 200) begin
         step();
         n++;
      end
      total++;
      if (n >= 200) begin
         bad++;
         $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
      end
   endtask

   initial begin
      int n0;
      int n;
      rst = 1'b1; gen_en = 1'b0; seed_load = 1'b0; seed_in = '0; out_ready = 1'b1;
      tb_ctr = '0;
      #12;
      check("reset_valid", PW'(out_valid), PW'(0));
      check("reset_perm", out_perm, PW'(0));
      check("reset_ctr", PW'(out_ctr), PW'(0));
      check("reset_ready", PW'(gen_ready), PW'(1));
      rst = 1'b0;
      step();

      req_check("identity", 64'hFEDCBA9876543210, 32'h0);
      req_check("shift1", 64'h0FEDCBA987654321, 32'h1);
      seed_load = 1'b1; seed_in = 32'h10;
      step();
      seed_load = 1'b0;
      req_check("seed10", 64'h210FEDCBA9876543, 32'h10);
      drain();

      do_reset();
      n0 = n_out;
      gen_en = 1'b1;
      for (int i = 0; i < 20; i++) step();
      drain();
      check("stream_count", PW'(n_out - n0), PW'(20));

      // backpressure: hold out_ready low for 5 cycles after first valid
      gen_en = 1'b1;
      n = 0;
      while (!out_valid && n < 40) begin step(); n++; end
      out_ready = 1'b0;
      step();
      for (int i = 0; i < 5; i++) begin
         check("bp_gen_ready", PW'(gen_ready), PW'(0));
         step();
      end
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) step();
      drain();

      // seed/wrap: same-cycle seed and request uses the old ctr
      seed_load = 1'b1; seed_in = '1; gen_en = 1'b1;
      step();
      seed_load = 1'b0;
      step();
      step();
      drain();

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         gen_en    = ($urandom % 4) != 0;
         out_ready = ($urandom % 3) != 0;
         seed_load = ($urandom % 16) == 0;
         seed_in   = CW'($urandom);
         step();
      end
      drain();

      // reset with 4 entries in flight
      gen_en = 1'b1;
      for (int i = 0; i < 4; i++) step();
      gen_en = 1'b0;
      do_reset();
      for (int i = 0; i < 12; i++) begin
         check("post_rst_no_valid", PW'(out_valid), PW'(0));
         step();
      end
      req_check("post_rst", 64'hFEDCBA9876543210, 32'h0);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
